// File: rtl/ddr_axi_burst_master.sv
// Single-burst AXI4 master in front of the DDR3 controller's 128-bit slave port.
// Takes one command at a time, issues one INCR burst, passes the W and R
// streams straight through, and reports completion status.
module ddr_axi_burst_master #(
  parameter logic [3:0] AXI_ID     = 4'h0,
  parameter int         ADDR_WIDTH = 28,
  parameter int         DATA_WIDTH = 128
) (
  input  logic                    axi_clk,
  input  logic                    aresetn,
  // command
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  // write stream
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  // read stream
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    rd_last,
  // status
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              done_status,
  // AW
  output logic [3:0]              m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  // W
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  // B
  input  logic [3:0]              m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  // AR
  output logic [3:0]              m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  // R
  input  logic [3:0]              m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WRITE, S_WAIT_B, S_READ, S_READ_DATA, S_DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic                  write_q;
  logic                  aw_done;
  logic                  w_done;
  logic                  rerr_q;

  // last beat index inside the 4KB page; bit 8 set means the burst spills over
  logic [8:0] page_end;
  assign page_end = {1'b0, addr_q[11:4]} + {1'b0, len_q};

  logic w_active, r_active, last_beat;
  assign w_active  = (state == S_WRITE) && !w_done;
  assign r_active  = (state == S_READ_DATA);
  assign last_beat = (beat_cnt == len_q);

  // Fixed AXI attributes: 16-byte INCR, normal access
  assign m_axi_awid    = AXI_ID;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'b100;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'h0;
  assign m_axi_awprot  = 3'h0;
  assign m_axi_awqos   = 4'h0;
  assign m_axi_arid    = AXI_ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'b100;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'h0;
  assign m_axi_arprot  = 3'h0;
  assign m_axi_arqos   = 4'h0;
  assign m_axi_wstrb   = '1;

  // W and R streams are zero-latency pass-throughs, closed outside their phase
  assign m_axi_wvalid  = w_active & wr_valid;
  assign wr_ready      = w_active & m_axi_wready;
  assign m_axi_wdata   = w_active ? wr_data : '0;
  assign m_axi_wlast   = w_active & last_beat;
  assign m_axi_bready  = (state == S_WAIT_B);
  assign rd_valid      = r_active & m_axi_rvalid;
  assign m_axi_rready  = r_active & rd_ready;
  assign rd_data       = r_active ? m_axi_rdata : '0;
  assign rd_last       = r_active & m_axi_rlast;
  assign busy          = (state != S_IDLE);

  logic aw_hs, w_hs, w_last_hs, r_hs, r_end, r_bad;
  assign aw_hs     = m_axi_awvalid & m_axi_awready;
  assign w_hs      = m_axi_wvalid & m_axi_wready;
  assign w_last_hs = w_hs & m_axi_wlast;
  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign r_end     = r_hs & (m_axi_rlast | last_beat);
  // rlast must coincide exactly with the expected final beat
  assign r_bad     = m_axi_rlast != last_beat;

  logic unused_ok;
  assign unused_ok = ^{m_axi_bid, m_axi_rid, m_axi_bresp[0], m_axi_rresp[0]};

  // Command sequencer: accept, screen, run one burst, report
  always_ff @(posedge axi_clk) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      cmd_ready     <= 1'b1;
      done          <= 1'b0;
      done_status   <= 2'd0;
      m_axi_awvalid <= 1'b0;
      m_axi_arvalid <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      write_q       <= 1'b0;
      beat_cnt      <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      rerr_q        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          addr_q    <= cmd_addr;
          len_q     <= cmd_len;
          write_q   <= cmd_write;
          cmd_ready <= 1'b0;
          state     <= S_CHECK;
        end
        S_CHECK: begin
          beat_cnt <= '0;
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          rerr_q   <= 1'b0;
          if (addr_q[3:0] != 4'h0 || page_end[8]) begin
            done        <= 1'b1;
            done_status <= 2'd1;
            state       <= S_DONE;
          end else if (write_q) begin
            m_axi_awvalid <= 1'b1;
            state         <= S_WRITE;
          end else begin
            m_axi_arvalid <= 1'b1;
            state         <= S_READ;
          end
        end
        S_WRITE: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs)      beat_cnt <= beat_cnt + 8'd1;
          if (w_last_hs) w_done   <= 1'b1;
          // AW and W may finish in either order
          if ((aw_done | aw_hs) && (w_done | w_last_hs)) state <= S_WAIT_B;
        end
        S_WAIT_B: if (m_axi_bvalid) begin
          done        <= 1'b1;
          done_status <= m_axi_bresp[1] ? 2'd2 : 2'd0;
          state       <= S_DONE;
        end
        S_READ: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          state         <= S_READ_DATA;
        end
        S_READ_DATA: if (r_hs) begin
          beat_cnt <= beat_cnt + 8'd1;
          if (m_axi_rresp[1]) rerr_q <= 1'b1;
          if (r_end) begin
            done        <= 1'b1;
            done_status <= r_bad ? 2'd3 : ((rerr_q | m_axi_rresp[1]) ? 2'd2 : 2'd0);
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          done_status <= 2'd0;
          cmd_ready   <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_axi_burst_master.sv
// Bench for ddr_axi_burst_master: behavioural DDR slave plus a word-level
// reference memory; directed scenarios followed by randomized commands.
module tb_ddr_axi_burst_master;

  logic         axi_clk = 1'b0;
  logic         aresetn = 1'b0;
  logic         cmd_valid = 1'b0, cmd_write = 1'b0;
  logic         cmd_ready;
  logic [27:0]  cmd_addr = '0;
  logic [7:0]   cmd_len = '0;
  logic [127:0] wr_data = '0;
  logic         wr_valid = 1'b0, wr_ready;
  logic [127:0] rd_data;
  logic         rd_valid, rd_last;
  logic         rd_ready = 1'b0;
  logic         busy, done;
  logic [1:0]   done_status;
  logic [3:0]   m_axi_awid, m_axi_awcache, m_axi_awqos, m_axi_arid, m_axi_arcache, m_axi_arqos;
  logic [27:0]  m_axi_awaddr, m_axi_araddr;
  logic [7:0]   m_axi_awlen, m_axi_arlen;
  logic [2:0]   m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
  logic [1:0]   m_axi_awburst, m_axi_arburst;
  logic         m_axi_awlock, m_axi_awvalid, m_axi_arlock, m_axi_arvalid;
  logic         m_axi_awready, m_axi_arready;
  logic [127:0] m_axi_wdata, m_axi_rdata;
  logic [15:0]  m_axi_wstrb;
  logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]   m_axi_bresp, m_axi_rresp;
  logic         m_axi_bvalid, m_axi_bready;
  logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;

  always #5 axi_clk = ~axi_clk;

  ddr_axi_burst_master dut (
    .axi_clk(axi_clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .busy(busy), .done(done), .done_status(done_status),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(4'h0), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(4'h0), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // ---------------- behavioural DDR slave ----------------
  bit          s_rand = 0, s_aw_delay = 0;
  logic [1:0]  s_bresp = 2'b00;
  int          s_rlast_at = -1, s_rerr_beat = -1;

  function automatic logic [127:0] pat(input logic [11:0] i);
    return {20'hC0DE0, i, ~{20'h0, i}, 32'h1234_0000 ^ {20'h0, i}, {i, i, 8'h5A}};
  endfunction

  logic [127:0] mem  [0:4095];
  bit           mem_v[0:4095];
  logic [127:0] wbuf [0:255];
  logic         aw_got, wl_got, r_act, r_gate;
  logic [11:0]  aw_idx, r_base;
  logic [7:0]   aw_len, w_cnt, r_len, r_beat;
  int           aw_dly;
  logic [11:0]  r_idx;

  wire aw_hs_s = m_axi_awvalid & m_axi_awready;
  wire w_hs_s  = m_axi_wvalid & m_axi_wready;
  wire ar_hs_s = m_axi_arvalid & m_axi_arready;
  wire r_hs_s  = m_axi_rvalid & m_axi_rready;

  assign r_idx        = r_base + 12'(r_beat);
  assign m_axi_rvalid = r_act & r_gate;
  assign m_axi_rdata  = mem_v[r_idx] ? mem[r_idx] : pat(r_idx);
  assign m_axi_rlast  = (s_rlast_at >= 0) ? (int'(r_beat) == s_rlast_at) : (r_beat == r_len);
  assign m_axi_rresp  = (int'(r_beat) == s_rerr_beat) ? 2'b10 : 2'b00;
  assign m_axi_bresp  = s_bresp;

  always @(posedge axi_clk) begin
    if (!aresetn) begin
      m_axi_awready <= 0; m_axi_wready <= 0; m_axi_arready <= 0; m_axi_bvalid <= 0;
      aw_got <= 0; wl_got <= 0; w_cnt <= 0; aw_dly <= 0; aw_idx <= 0; aw_len <= 0;
      r_act <= 0; r_gate <= 0; r_base <= 0; r_len <= 0; r_beat <= 0;
    end else begin
      if (aw_hs_s) begin aw_got <= 1; aw_idx <= m_axi_awaddr[15:4]; aw_len <= m_axi_awlen; end
      aw_dly <= (wl_got && !aw_got) ? aw_dly + 1 : 0;
      if (s_aw_delay) m_axi_awready <= (aw_dly >= 10) && !aw_got && !aw_hs_s;
      else            m_axi_awready <= s_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready <= s_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_hs_s) begin
        wbuf[w_cnt] <= m_axi_wdata;
        w_cnt <= w_cnt + 8'd1;
        if (m_axi_wlast) wl_got <= 1;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        m_axi_bvalid <= 0; aw_got <= 0; wl_got <= 0; w_cnt <= 0;
        for (int i = 0; i < 256; i++)
          if (i <= int'(aw_len)) begin
            mem[aw_idx + 12'(i)]   <= wbuf[i];
            mem_v[aw_idx + 12'(i)] <= 1'b1;
          end
      end else if (!m_axi_bvalid && (aw_got || aw_hs_s) && (wl_got || (w_hs_s && m_axi_wlast))
                   && (!s_rand || $urandom_range(0, 1) == 1))
        m_axi_bvalid <= 1;
      m_axi_arready <= s_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ar_hs_s) begin
        r_act <= 1; r_base <= m_axi_araddr[15:4]; r_len <= m_axi_arlen; r_beat <= 0;
      end
      r_gate <= s_rand ? (($urandom_range(0, 1) == 1) || (r_gate && !r_hs_s)) : 1'b1;
      if (r_hs_s) begin
        r_beat <= r_beat + 8'd1;
        if (m_axi_rlast || r_beat == r_len) r_act <= 0;
      end
    end
  end

  // ---------------- reference memory ----------------
  logic [127:0] ref_d[0:4095];
  bit           ref_v[0:4095];
  function automatic logic [127:0] ref_rd(input logic [11:0] i);
    return ref_v[i] ? ref_d[i] : pat(i);
  endfunction

  int n_cmp = 0, n_bad = 0;

  // per-command observations gathered by run_cmd
  logic [127:0] w_data[0:255];
  logic [127:0] r_data[0:255];
  bit           wv_rand = 0;
  int           rr_mode = 0;
  bit           done_seen, axi_seen, cr_at_done;
  int           done_cyc, w_hs_n, wl_n, wl_idx, r_n, r_last_idx, rready_bad, aw_at_w;
  logic [1:0]   done_stat;
  logic [27:0]  aw_addr_seen;
  logic [7:0]   aw_len_seen;
  logic [2:0]   aw_size_seen;
  logic [1:0]   aw_burst_seen;

  task automatic apply_reset();
    cmd_valid = 0; wr_valid = 0; rd_ready = 0; aresetn = 0;
    repeat (2) @(negedge axi_clk);
    aresetn = 1;
    @(negedge axi_clk);
  endtask

  // Issue one command and run both streams until done; cycle 1 = CHECK cycle.
  task automatic run_cmd(input bit wr, input logic [27:0] a, input logic [7:0] l);
    int cyc, widx, wait_n;
    bit whs, rhs, rl;
    logic [127:0] rc;
    done_seen = 0; axi_seen = 0; w_hs_n = 0; wl_n = 0; wl_idx = -1; r_n = 0;
    r_last_idx = -1; rready_bad = 0; done_cyc = -1; done_stat = '0; aw_at_w = -1;
    cr_at_done = 1'bx;
    @(negedge axi_clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    #1; wait_n = 0;
    while (!cmd_ready && wait_n < 100) begin @(negedge axi_clk); #1; wait_n++; end
    @(negedge axi_clk);
    cmd_valid = 0;
    cyc = 1; widx = 0; whs = 0; rhs = 0; rl = 0; rc = '0;
    while (!done_seen && cyc < 3000) begin
      if (whs) widx++;
      if (rhs) begin
        if (r_n < 256) r_data[r_n] = rc;
        if (rl) r_last_idx = r_n;
        r_n++;
      end
      wr_valid = wr && (widx <= int'(l)) && (!wv_rand || $urandom_range(0, 1) == 1);
      wr_data  = (widx <= int'(l)) ? w_data[widx] : '0;
      case (rr_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 2 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      whs = wr_valid && wr_ready; rhs = rd_valid && rd_ready; rc = rd_data; rl = rd_last;
      if (m_axi_awvalid && !axi_seen) begin
        aw_addr_seen = m_axi_awaddr; aw_len_seen = m_axi_awlen;
        aw_size_seen = m_axi_awsize; aw_burst_seen = m_axi_awburst;
      end
      if (m_axi_awvalid || m_axi_arvalid) axi_seen = 1;
      if (rd_valid && (m_axi_rready !== rd_ready)) rready_bad++;
      if (m_axi_wvalid && m_axi_wready) begin
        w_hs_n++;
        if (m_axi_wlast) begin wl_n++; wl_idx = w_hs_n - 1; end
      end
      if (m_axi_awvalid && m_axi_awready) aw_at_w = w_hs_n;
      if (done) begin
        done_seen = 1; done_stat = done_status; done_cyc = cyc; cr_at_done = cmd_ready;
      end else begin
        @(negedge axi_clk); cyc++;
      end
    end
    wr_valid = 0; rd_ready = 0;
    if (!done_seen) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_timeout addr=%h len=%0d: no done within %0d cycles", a, l, cyc);
      apply_reset();
    end else
      @(negedge axi_clk);
  endtask

  task automatic ref_write(input logic [27:0] a, input logic [7:0] l);
    for (int i = 0; i <= int'(l); i++) begin
      ref_d[a[15:4] + 12'(i)] = w_data[i];
      ref_v[a[15:4] + 12'(i)] = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [11:0] obs, req;
    apply_reset();
    #1;
    obs = {cmd_ready, busy, done, done_status, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
           m_axi_bready, m_axi_rready, wr_ready, rd_valid};
    req = 12'b1000_0000_0000;
    n_cmp++;
    if (obs !== req) begin n_bad++; $display("FAIL reset_outputs got=%b want=%b", obs, req); end
    n_cmp++;
    if (rd_data !== '0 || m_axi_wdata !== '0 || m_axi_wlast !== 1'b0 || rd_last !== 1'b0) begin
      n_bad++; $display("FAIL reset_data got rd=%h wd=%h want 0", rd_data, m_axi_wdata);
    end
  endtask

  task automatic test_write_basic();
    s_rand = 0; s_aw_delay = 0; s_bresp = 2'b00; wv_rand = 0; rr_mode = 0;
    for (int i = 0; i < 4; i++) w_data[i] = {32'hDA7A0000, 64'h0, 32'(i + 1)};
    run_cmd(1'b1, 28'h0000100, 8'd3);
    ref_write(28'h0000100, 8'd3);
    n_cmp++; if (done_stat !== 2'd0) begin n_bad++; $display("FAIL wr_status got=%0d want=0", done_stat); end
    n_cmp++; if (done_cyc !== 7) begin n_bad++; $display("FAIL wr_latency got=%0d want=7", done_cyc); end
    n_cmp++; if (aw_addr_seen !== 28'h0000100 || aw_len_seen !== 8'd3) begin
      n_bad++; $display("FAIL wr_aw_fields got addr=%h len=%0d want 100/3", aw_addr_seen, aw_len_seen); end
    n_cmp++; if (aw_size_seen !== 3'b100 || aw_burst_seen !== 2'b01) begin
      n_bad++; $display("FAIL wr_aw_attr got size=%b burst=%b want 100/01", aw_size_seen, aw_burst_seen); end
    n_cmp++; if (w_hs_n !== 4 || wl_n !== 1 || wl_idx !== 3) begin
      n_bad++; $display("FAIL wr_wlast got beats=%0d lasts=%0d at=%0d want 4/1/3", w_hs_n, wl_n, wl_idx); end
    n_cmp++; if (cr_at_done !== 1'b0) begin
      n_bad++; $display("FAIL wr_cmd_ready_at_done got=%b want=0", cr_at_done); end
  endtask

  task automatic test_read_toggle();
    int bad;
    s_rand = 0; rr_mode = 1;
    run_cmd(1'b0, 28'h0000100, 8'd3);
    bad = 0;
    for (int i = 0; i < 4; i++) if (r_data[i] !== ref_rd(12'h010 + 12'(i))) bad++;
    n_cmp++; if (done_stat !== 2'd0) begin n_bad++; $display("FAIL rd_status got=%0d want=0", done_stat); end
    n_cmp++; if (r_n !== 4 || bad !== 0) begin
      n_bad++; $display("FAIL rd_data got beats=%0d bad=%0d want 4/0", r_n, bad); end
    n_cmp++; if (r_last_idx !== 3) begin n_bad++; $display("FAIL rd_last got=%0d want=3", r_last_idx); end
    n_cmp++; if (rready_bad !== 0) begin n_bad++; $display("FAIL rd_rready_mirror got=%0d want=0", rready_bad); end
    rr_mode = 0;
  endtask

  task automatic test_reject();
    run_cmd(1'b1, 28'h0000FF0, 8'd1);
    n_cmp++; if (done_stat !== 2'd1 || done_cyc !== 2) begin
      n_bad++; $display("FAIL rej_4k got status=%0d cyc=%0d want 1/2", done_stat, done_cyc); end
    n_cmp++; if (axi_seen !== 1'b0) begin n_bad++; $display("FAIL rej_4k_axi got=%b want=0", axi_seen); end
    run_cmd(1'b0, 28'h0000008, 8'd0);
    n_cmp++; if (done_stat !== 2'd1 || axi_seen !== 1'b0) begin
      n_bad++; $display("FAIL rej_align got status=%0d axi=%b want 1/0", done_stat, axi_seen); end
  endtask

  task automatic test_aw_delay();
    s_rand = 0; s_aw_delay = 1; s_bresp = 2'b10;
    for (int i = 0; i < 4; i++) w_data[i] = {64'hBEEF, 32'h0, 32'(i + 16)};
    run_cmd(1'b1, 28'h0000200, 8'd3);
    ref_write(28'h0000200, 8'd3);
    n_cmp++; if (done_stat !== 2'd2) begin n_bad++; $display("FAIL awdly_status got=%0d want=2", done_stat); end
    n_cmp++; if (w_hs_n !== 4 || aw_at_w !== 4) begin
      n_bad++; $display("FAIL awdly_order got beats=%0d aw_after=%0d want 4/4", w_hs_n, aw_at_w); end
    n_cmp++; if (done_cyc < 16) begin n_bad++; $display("FAIL awdly_wait got cyc=%0d want>=16", done_cyc); end
    s_aw_delay = 0; s_bresp = 2'b00;
  endtask

  task automatic test_read_errors();
    int bad;
    s_rlast_at = 4;
    run_cmd(1'b0, 28'h0000300, 8'd7);
    bad = 0;
    for (int i = 0; i < 5; i++) if (r_data[i] !== ref_rd(12'h030 + 12'(i))) bad++;
    n_cmp++; if (done_stat !== 2'd3 || r_n !== 5) begin
      n_bad++; $display("FAIL rlast_early got status=%0d beats=%0d want 3/5", done_stat, r_n); end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL rlast_early_data got bad=%0d want=0", bad); end
    s_rlast_at = -1; s_rerr_beat = 1;
    run_cmd(1'b0, 28'h0000100, 8'd3);
    n_cmp++; if (done_stat !== 2'd2 || r_n !== 4) begin
      n_bad++; $display("FAIL rresp_err got status=%0d beats=%0d want 2/4", done_stat, r_n); end
    s_rerr_beat = -1;
  endtask

  task automatic test_reset_mid();
    logic [8:0] obs;
    @(negedge axi_clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 28'h0000800; cmd_len = 8'd7;
    @(negedge axi_clk);
    cmd_valid = 0; wr_valid = 1; wr_data = 128'h5EED;
    repeat (4) @(negedge axi_clk);
    aresetn = 0;
    @(negedge axi_clk);
    #1;
    obs = {cmd_ready, busy, done, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
           m_axi_bready, m_axi_rready, wr_ready};
    n_cmp++;
    if (obs !== 9'b1_0000_0000) begin n_bad++; $display("FAIL reset_mid got=%b want=100000000", obs); end
    wr_valid = 0; aresetn = 1;
    @(negedge axi_clk);
  endtask

  task automatic test_random();
    bit wr, rej;
    logic [27:0] a;
    logic [7:0] l;
    int endb, exp_n, bad;
    logic [1:0] exp_s;
    s_rand = 1; wv_rand = 1; rr_mode = 2;
    for (int k = 0; k < 30; k++) begin
      wr = 1'($urandom_range(0, 1));
      a  = {12'h0, 12'($urandom_range(0, 4095)), 4'h0};
      if ($urandom_range(0, 5) == 0) a[3:0] = 4'($urandom_range(1, 15));
      l  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      s_bresp     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      s_rlast_at  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : -1;
      s_rerr_beat = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : -1;
      for (int i = 0; i < 256; i++) w_data[i] = {$urandom, $urandom, $urandom, $urandom};
      rej = (a[3:0] != 4'h0) || (int'(a[11:4]) + int'(l) > 255);
      endb = (s_rlast_at >= 0 && s_rlast_at < int'(l)) ? s_rlast_at : int'(l);
      exp_n = endb + 1;
      if (rej)     exp_s = 2'd1;
      else if (wr) exp_s = s_bresp[1] ? 2'd2 : 2'd0;
      else if (s_rlast_at >= 0 && s_rlast_at != int'(l)) exp_s = 2'd3;
      else if (s_rerr_beat >= 0 && s_rerr_beat <= endb)  exp_s = 2'd2;
      else exp_s = 2'd0;
      run_cmd(wr, a, l);
      n_cmp++;
      if (done_stat !== exp_s) begin
        n_bad++; $display("FAIL rand_status[%0d] wr=%b addr=%h len=%0d got=%0d want=%0d",
                          k, wr, a, l, done_stat, exp_s);
      end
      if (rej) begin
        n_cmp++; if (axi_seen !== 1'b0) begin n_bad++; $display("FAIL rand_rej_axi[%0d] got=1 want=0", k); end
      end else if (wr) begin
        ref_write(a, l);
        n_cmp++; if (w_hs_n !== int'(l) + 1) begin
          n_bad++; $display("FAIL rand_wbeats[%0d] got=%0d want=%0d", k, w_hs_n, int'(l) + 1); end
      end else begin
        bad = 0;
        for (int i = 0; i < exp_n && i < 256; i++) if (r_data[i] !== ref_rd(a[15:4] + 12'(i))) bad++;
        n_cmp++; if (r_n !== exp_n || bad !== 0) begin
          n_bad++; $display("FAIL rand_rdata[%0d] got beats=%0d bad=%0d want %0d/0", k, r_n, bad, exp_n); end
      end
    end
    s_rand = 0; wv_rand = 0; rr_mode = 0; s_bresp = 2'b00; s_rlast_at = -1; s_rerr_beat = -1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_v[i] = 1'b0;
    test_reset();
    test_write_basic();
    test_read_toggle();
    test_reject();
    test_aw_delay();
    test_read_errors();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr_axi_burst_master.md
Name: ddr_axi_burst_master

Overview:
- AXI4 master that sits directly upstream of the DDR3 controller's 128-bit AXI4 slave port.
- Converts simple single-burst commands (from the JTAG command decoder) into one AXI4 INCR write or read burst.
- Write data enters and read data leaves as valid/ready streams.
- Reports per-command completion and response status.

Parameters:
- AXI_ID, 4'h0, constant value driven on m_axi_awid/m_axi_arid.
- ADDR_WIDTH, 28, byte address width; matches the DDR slave.
- DATA_WIDTH, 128, beat width; fixed at 128 (16 bytes/beat).

Ports:
- axi_clk  in  1  clock; the controller ui_clk domain.
- aresetn  in  1  synchronous reset, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start byte address.
- cmd_len  in  8  beats minus one (AXI len encoding).
- wr_data  in  128  write beat data.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accepted.
- rd_data  out  128  read beat data.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  read beat consumed.
- rd_last  out  1  final read beat.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle completion pulse.
- done_status  out  2  0 = OKAY, 1 = rejected (alignment/4KB), 2 = SLVERR/DECERR seen, 3 = RLAST mismatch.
- m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  AXI4 master channels. Widths are identical to the DDR slave: id 4, addr 28, len 8, size 3, burst 2, lock 1, cache 4, prot 3, qos 4, data 128, strb 16, resp 2.

Behaviour:
- Reset (aresetn low at a rising edge): state IDLE. All outputs are 0 except cmd_ready = 1.
- Aborting a transfer with reset leaves the slave side undefined. The bench resets the DUT and the DDR slave together.
- Constant AXI fields:
  - size = 3'b100, burst = 2'b01 (INCR), lock/cache/prot/qos = 0.
  - wstrb = all ones, bready = 1 only in WAIT_B.
- cmd_ready is high only in IDLE. On accept, latch addr/len/write and go to CHECK.
- CHECK (1 cycle):
  - Reject if cmd_addr[3:0] != 0, or cmd_addr[11:4] + cmd_len > 255 (burst crosses a 4KB boundary).
  - On reject: go to DONE with status 1; no AXI activity occurs.
  - Otherwise go to WRITE or READ.
- WRITE:
  - awvalid is asserted on entry and held, with stable addr/len, until awready. An aw_done flag is set at that handshake.
  - The W channel runs concurrently: wvalid = wr_valid, wr_ready = wready, wdata = wr_data (combinational pass-through, zero latency).
  - Beat counter starts at 0 and increments per W handshake. wlast = (beat_cnt == len_q).
  - Once the last W handshake has occurred and aw_done is set, go to WAIT_B. This also holds when awready arrives after the final W beat.
  - wvalid and wr_ready are forced to 0 after the last beat.
- WAIT_B: on bvalid, status = 2 if bresp[1], else 0. Go to DONE.
- READ:
  - arvalid is held until arready; then go to READ_DATA.
- READ_DATA:
  - rd_valid = rvalid, rready = rd_ready, rd_data = rdata, rd_last = rlast (pass-through).
  - The counter increments per R handshake.
  - Any rresp[1] sets sticky error 2.
  - If rlast arrives on a beat other than len_q, record status 3; priority is 3 over 2 over 0.
  - If the counter reaches len_q without rlast, status is 3.
  - On the handshake of the beat where rlast or count == len_q: go to DONE.
- DONE (1 cycle): done = 1 and done_status valid for that cycle only. busy falls; next state IDLE.
- busy = (state != IDLE).
- Only one outstanding command at a time. A new command cannot be accepted in the same cycle that done pulses.
- Back-to-back latency: command accept -> awvalid/arvalid is 2 cycles (accept edge, CHECK).

Test Plan:
- Write cmd addr 0x0000100, len 3; 4 beats 0x…01..0x…04 with wr_valid always high; slave ready always high -> awaddr = 0x0000100, awlen = 3, wlast on beat 4 only, done with status 0, 7 cycles from accept to done.
- Read back the same address, len 3, with rd_ready toggling 1/0 -> rd_data equals the written data in order, rd_last on beat 4, rready mirrors rd_ready, done status 0.
- cmd_addr 0x0000FF0, len 1 (crosses 4KB) -> no awvalid/arvalid ever, done status 1 two cycles after accept.
- cmd_addr 0x0000008 -> status 1 (misaligned).
- awready delayed 10 cycles after all 4 W beats complete -> state waits; bvalid with bresp = 2'b10 -> status 2.
- Read len 7, slave asserts rlast on beat 5 -> status 3, done after beat 5.
- Assert aresetn low mid-W-burst -> next cycle: all AXI valids 0, cmd_ready 1, busy 0.
